// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: streams a WIDTH-bit operation through one 1-bit slice, LSB first.
// Start/busy/done handshake; SLT adds one fix-up cycle after the subtract pass.
module alu_serial_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  // state    | meaning
  // S_IDLE   | waiting for start_i
  // S_RUN    | one operand bit per clock through the slice
  // S_SLT_FIX| turn the subtract result into the SLT bit
  // S_DONE   | one-cycle completion pulse, may accept a new op
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SLT_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_sh_q, res_sh_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             ainv_q, ainv_d, binv_q, binv_d;
  logic             slt_q, slt_d, unsup_q, unsup_d;
  logic             carry_q, carry_d, c_msb_q, c_msb_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic             a_bit, b_bit, sum_bit, carry_nxt, slice_bit, last_bit, accept, arith;
  logic [WIDTH-1:0] shifted;

  assign a_bit     = a_q[0] ^ ainv_q;
  assign b_bit     = b_q[0] ^ binv_q;
  assign sum_bit   = a_bit ^ b_bit ^ carry_q;
  assign carry_nxt = (a_bit & b_bit) | (carry_q & (a_bit | b_bit));
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
  assign arith     = (op_q == 2'b10) && !unsup_q;
  assign shifted   = {slice_bit, res_sh_q[WIDTH-1:1]};

  always_comb begin
    case (op_q)
      2'b00:   slice_bit = a_bit & b_bit;
      2'b01:   slice_bit = a_bit | b_bit;
      2'b10:   slice_bit = sum_bit;
      default: slice_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    ainv_d   = ainv_q;
    binv_d   = binv_q;
    slt_d    = slt_q;
    unsup_d  = unsup_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    if (accept) begin
      state_d = S_RUN;
      a_d     = src1_i;
      b_d     = src2_i;
      cnt_d   = '0;
      op_d    = 2'b00;
      ainv_d  = 1'b0;
      binv_d  = 1'b0;
      slt_d   = 1'b0;
      unsup_d = 1'b0;
      carry_d = 1'b0;
      case (ctrl_i)
        4'b0000: op_d = 2'b00;
        4'b0001: op_d = 2'b01;
        4'b0010: op_d = 2'b10;
        4'b0110: begin op_d = 2'b10; binv_d = 1'b1; carry_d = 1'b1; end
        4'b0111: begin op_d = 2'b10; binv_d = 1'b1; carry_d = 1'b1; slt_d = 1'b1; end
        4'b1100: begin op_d = 2'b00; ainv_d = 1'b1; binv_d = 1'b1; end
        default: unsup_d = 1'b1;
      endcase
    end else begin
      case (state_q)
        S_RUN: begin
          res_sh_d = shifted;
          a_d      = {1'b0, a_q[WIDTH-1:1]};
          b_d      = {1'b0, b_q[WIDTH-1:1]};
          cnt_d    = cnt_q + CNT_W'(1);
          carry_d  = carry_nxt;
          if (last_bit) begin
            c_msb_d = carry_q;
            if (slt_q) begin
              state_d = S_SLT_FIX;
            end else begin
              state_d  = S_DONE;
              result_d = unsup_q ? '0 : shifted;
              cout_d   = arith & carry_nxt;
              ovf_d    = arith & (carry_nxt ^ carry_q);
            end
          end
        end
        S_SLT_FIX: begin
          // sign of the difference corrected by overflow gives signed less-than
          state_d  = S_DONE;
          result_d = {{(WIDTH-1){1'b0}}, res_sh_q[WIDTH-1] ^ carry_q ^ c_msb_q};
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= 2'b00;
      ainv_q   <= 1'b0;
      binv_q   <= 1'b0;
      slt_q    <= 1'b0;
      unsup_q  <= 1'b0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      ainv_q   <= ainv_d;
      binv_q   <= binv_d;
      slt_q    <= slt_d;
      unsup_q  <= unsup_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy_o     = (state_q == S_RUN) || (state_q == S_SLT_FIX);
  assign done_o     = (state_q == S_DONE);
  assign result_o   = result_q;
  assign zero_o     = (result_q == '0);
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized + directed bench for alu_serial_seq against a plain-arithmetic reference.
module tb_alu_serial_seq;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         start_i = 1'b0;
  logic [3:0]   ctrl_i = 4'h0;
  logic [W-1:0] src1_i = '0, src2_i = '0;
  logic         busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [W-1:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;

  alu_serial_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ctrl_i(ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic co, output logic ov,
                                output int lat);
    logic [W:0] s;
    r = '0; co = 1'b0; ov = 1'b0; lat = W;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0110: begin
        s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'b0111: begin
        r   = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
        lat = W + 1;
      end
      default: ;
    endcase
  endfunction

  // Presents an op with start high, then follows it to completion from the accept edge.
  task automatic run(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                     input bit noisy, input bit chain);
    logic [W-1:0] er, held;
    logic         eco, eov;
    int           lat, n;
    model(c, a, b, er, eco, eov, lat);
    ctrl_i = c; src1_i = a; src2_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0;
    while (n < 60) begin
      if (noisy) begin
        start_i = (n == 5 || n == 20 || $urandom_range(0, 3) == 0);
        src1_i  = $urandom;
        src2_i  = $urandom;
        ctrl_i  = 4'($urandom);
      end
      @(posedge clk_i); #1;
      n++;
      if (done_o) break;
      chk("busy_run", busy_o, 1'b1);
    end
    start_i = 1'b0;
    chk("latency", n, lat);
    chk("done", done_o, 1'b1);
    chk("busy_done", busy_o, 1'b0);
    chk("result", result_o, er);
    chk("zero", zero_o, (er == '0));
    chk("cout", cout_o, eco);
    chk("ovf", overflow_o, eov);
    if (!chain) begin
      held = result_o;
      @(posedge clk_i); #1;
      chk("done_pulse", done_o, 1'b0);
      chk("busy_idle", busy_o, 1'b0);
      chk("result_hold", result_o, held);
    end
  endtask

  logic [3:0] ctrl_set [8] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h3, 4'hF};

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int hi;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_result", result_o, '0);
    chk("rst_zero", zero_o, 1'b1);
    chk("rst_cout", cout_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;

    run(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 1, 0);
    run(4'h6, 32'h0000_0005, 32'h0000_0005, 0, 0);
    run(4'h6, 32'h8000_0000, 32'h0000_0001, 0, 0);
    run(4'h7, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
    run(4'h7, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
    run(4'hC, 32'h0000_0000, 32'h0000_0000, 0, 0);
    run(4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0);
    run(4'h1, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0);
    run(4'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run(4'h2, 32'h1234_5678, 32'h1111_1111, 0, 1);
    run(4'h2, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);

    // reset in the middle of a subtract
    ctrl_i = 4'h6; src1_i = 32'h0000_00FF; src2_i = 32'h0000_0001; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    chk("arst_result", result_o, '0);
    chk("arst_zero", zero_o, 1'b1);
    @(negedge clk_i) rst_i = 1'b1;
    hi = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (done_o) hi++;
    end
    chk("arst_no_done", hi, 0);
    run(4'h2, 32'd3, 32'd4, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run(ctrl_set[$urandom_range(0, 7)], rand_op(), rand_op(),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0));
    end
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial multi-cycle ALU that sequences a WIDTH-bit operation through a single 1-bit slice datapath, LSB first, one bit per clock.
- Per bit it drives the slice controls: operation, A_invert, B_invert, carry-in and less. It feeds the registered carry-out back as the next carry-in and shifts result bits into an output register.
- Serves as the area-reduced, multi-cycle execution-unit alternative to the ripple ALU. Handshake is start/busy/done toward the datapath controller.

Parameters:
WIDTH, 32, operand/result width in bits (≥2)
CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
start_i  input  1  request; sampled only when accepting (IDLE or DONE)
ctrl_i  input  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
src1_i  input  WIDTH  operand A
src2_i  input  WIDTH  operand B
busy_o  output  1  high in RUN and SLT_FIX
done_o  output  1  one-cycle completion pulse
result_o  output  WIDTH  registered result, held until next completion
zero_o  output  1  result_o == 0
cout_o  output  1  carry out of MSB (ADD/SUB only, else 0)
overflow_o  output  1  signed overflow (ADD/SUB only, else 0)

Behaviour:
- Reset (rst_i low, asynchronous): state=IDLE; busy_o, done_o, cout_o, overflow_o=0; result_o=0; zero_o=1; counter=0. Reset mid-operation aborts with no done_o.
- Control decode, latched at accept:
  - AND: op=00.
  - OR: op=01.
  - ADD: op=10, cin0=0.
  - SUB: op=10, B_invert=1, cin0=1.
  - SLT: same as SUB, plus SLT_FIX.
  - NOR: op=00, A_invert=B_invert=1.
  - Any other code: result 0, flags 0, same latency as ADD.
- Accept: at an edge where state∈{IDLE,DONE} and start_i=1, latch src1_i, src2_i and ctrl_i into shift registers, set carry=cin0, counter=0, state→RUN.
- Inputs changing after accept are ignored. start_i in RUN/SLT_FIX is ignored (no queueing).
- RUN, per edge:
  - Compute bit i from the operand LSBs.
  - Sum bit = a^b^carry; carry_next = a&b | carry&(a|b).
  - Shift the result bit in at MSB of the result shift register; shift both operands right; counter++.
  - Record carry-in of bit WIDTH-1 as c_msb_in.
- Leaving RUN: on the edge processing bit WIDTH-1, go to DONE; for SLT go to SLT_FIX instead.
- Result write at that same edge (non-SLT): result_o gets the full shifted value, cout_o=final carry, overflow_o=final carry^c_msb_in.
- SLT_FIX (one cycle): result_o={0…0, sum[WIDTH-1]^overflow}, cout_o=0, overflow_o=0.
- DONE: done_o=1 for exactly one cycle, busy_o=0. Next state is RUN if start_i=1 (back-to-back), else IDLE.
- Latency, start accepted at edge k:
  - done_o is high in the cycle after edge k+WIDTH (non-SLT).
  - done_o is high in the cycle after edge k+WIDTH+1 (SLT).
- Output timing:
  - zero_o is derived combinationally from result_o.
  - result_o and the flags change only at the completion edge and are stable while done_o is high and afterwards.
- Arithmetic is modulo 2^WIDTH; no exceptions.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001, start at edge 0 -> done_o high in the cycle after edge 32; result 0x80000000, overflow_o=1, cout_o=0, zero_o=0.
- SUB 0x00000005-0x00000005 -> result 0, zero_o=1, cout_o=1, overflow_o=0. SUB 0x80000000-0x00000001 -> 0x7FFFFFFF, overflow_o=1.
- SLT src1=0xFFFFFFFF, src2=0x00000001 -> result 0x00000001, done in the cycle after edge 33. SLT 0x7FFFFFFF vs 0x80000000 -> 0x00000000 (overflow-corrected).
- NOR 0x00000000,0x00000000 -> 0xFFFFFFFF. AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000. OR same operands -> 0xFFF0FFF0. Unsupported ctrl 0x3 -> 0, flags 0.
- Handshake:
  - start_i pulsed at cycles 5 and 20 of an ADD: ignored, and the result is unaffected by src changes after accept.
  - start_i held during the done cycle: new op starts with no IDLE gap; second done 32 cycles later.
- Reset: assert rst_i low at bit 10 of a SUB -> busy_o, done_o and result_o go to 0 immediately; no done pulse. After release, a fresh ADD 3+4 -> 7.
